// File: rtl/chain_prbs_checker.sv
// Pin-chain loopback self-test: drives per-chain PRBS into the chain heads and checks the synchronised tails.
// One vector per SETTLE+1 cycles; all outputs come from flops; no flow control (start_i is ignored while busy).
module chain_prbs_checker #(
  parameter int N_CHAINS    = 3,
  parameter int SETTLE      = 4,
  parameter int NUM_VECTORS = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [N_CHAINS-1:0] sense_i,
  output logic [N_CHAINS-1:0] drive_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [N_CHAINS-1:0] fail_mask_o,
  output logic [7:0]          err_count_o
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);
  localparam logic [15:0]   LAST_VEC    = 16'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  function automatic logic [7:0] seed_of(input int k);
    return 8'hA5 ^ (8'(k) * 8'h11);
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  state_t              state_q, state_d;
  logic [7:0]          lfsr_q [N_CHAINS];
  logic [7:0]          lfsr_d [N_CHAINS];
  logic [15:0]         vec_cnt_q, vec_cnt_d;
  logic [SW-1:0]       settle_cnt_q, settle_cnt_d;
  logic [N_CHAINS-1:0] fail_mask_q, fail_mask_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic [N_CHAINS-1:0] sync1_q, sync2_q;
  logic [N_CHAINS-1:0] drive_q, drive_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [N_CHAINS-1:0] mism;

  // drive_q only changes on the SAMPLE->SETTLE edge, so it is stable across the whole compare window
  assign mism = sync2_q ^ drive_q;

  always_comb begin
    state_d      = state_q;
    vec_cnt_d    = vec_cnt_q;
    settle_cnt_d = settle_cnt_q;
    fail_mask_d  = fail_mask_q;
    err_cnt_d    = err_cnt_q;
    for (int k = 0; k < N_CHAINS; k++) begin
      lfsr_d[k] = lfsr_q[k];
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d      = S_SETTLE;
          vec_cnt_d    = '0;
          settle_cnt_d = SETTLE_LOAD;
          fail_mask_d  = '0;
          err_cnt_d    = '0;
          for (int k = 0; k < N_CHAINS; k++) begin
            lfsr_d[k] = seed_of(k);
          end
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end
      end
      S_SAMPLE: begin
        fail_mask_d = fail_mask_q | mism;
        if ((|mism) && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
        if (vec_cnt_q == LAST_VEC) begin
          state_d = S_DONE;
        end else begin
          state_d      = S_SETTLE;
          vec_cnt_d    = vec_cnt_q + 16'd1;
          settle_cnt_d = SETTLE_LOAD;
          for (int k = 0; k < N_CHAINS; k++) begin
            lfsr_d[k] = lfsr_step(lfsr_q[k]);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are precomputed from next state so every port is a flop output
    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (fail_mask_d == '0);
    for (int k = 0; k < N_CHAINS; k++) begin
      drive_d[k] = busy_d & lfsr_d[k][0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      vec_cnt_q    <= '0;
      settle_cnt_q <= '0;
      fail_mask_q  <= '0;
      err_cnt_q    <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      drive_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      for (int k = 0; k < N_CHAINS; k++) begin
        lfsr_q[k] <= seed_of(k);
      end
    end else begin
      state_q      <= state_d;
      vec_cnt_q    <= vec_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      fail_mask_q  <= fail_mask_d;
      err_cnt_q    <= err_cnt_d;
      sync1_q      <= sense_i;
      sync2_q      <= sync1_q;
      drive_q      <= drive_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      for (int k = 0; k < N_CHAINS; k++) begin
        lfsr_q[k] <= lfsr_d[k];
      end
    end
  end

  assign drive_o     = drive_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_mask_o = fail_mask_q;
  assign err_count_o = err_cnt_q;

endmodule
